// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if: requester-side handshake bundle for the multiply sequencer.
// master = CPU-side requester, slave = alu_mul_seq.
interface alu_mul_seq_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b,
    input  busy, done, product, ovf, zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, product, ovf, zero
  );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned multiplier that borrows the shared Hack ALU and runs an
// MSB-first shift-and-add loop (DBL doubles acc, ADD adds mcand when the
// current multiplier bit is set). Product is the low WIDTH bits of a*b.
// Optional feature: define ALU_MUL_OVF_EN to get a sticky unsigned overflow
// flag on req.ovf; otherwise req.ovf is tied low.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_mul_seq_if.slave     req,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zr,
  input  logic             alu_ng
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DBL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   product_q, product_d;
  logic               zero_q, zero_d;
  logic               busy_c;
  logic               done_c;
  logic               bit_end;

  // Sign flag of the ALU has no role in unsigned multiply.
  logic alu_ng_unused;
  assign alu_ng_unused = alu_ng;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      zero_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      zero_q    <= zero_d;
    end
  end

  // Next-state, ALU control decode and handshake outputs.
  // The product is captured from alu_out on the final compute cycle so it is
  // already valid in the cycle where done is high.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    zero_d    = zero_q;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    bit_end   = 1'b0;
    alu_x     = '0;
    alu_y     = '0;
    // constant-zero function: zx nx zy ny f no = 101010
    alu_zx    = 1'b1;
    alu_nx    = 1'b0;
    alu_zy    = 1'b1;
    alu_ny    = 1'b0;
    alu_f     = 1'b1;
    alu_no    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req.start) begin
          mcand_d  = req.a;
          mplier_d = req.b;
          acc_d    = '0;
          cnt_d    = CNT_W'(WIDTH - 1);
          state_d  = DBL;
        end
      end
      DBL: begin
        busy_c = 1'b1;
        alu_x  = acc_q;
        alu_y  = acc_q;
        alu_zx = 1'b0;
        alu_zy = 1'b0;
        acc_d  = alu_out;
        if (mplier_q[cnt_q]) begin
          state_d = ADD;
        end else begin
          bit_end = 1'b1;
        end
      end
      ADD: begin
        busy_c  = 1'b1;
        alu_x   = acc_q;
        alu_y   = mcand_q;
        alu_zx  = 1'b0;
        alu_zy  = 1'b0;
        acc_d   = alu_out;
        bit_end = 1'b1;
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bit_end) begin
      if (cnt_q == '0) begin
        state_d   = DONE;
        product_d = alu_out;
        zero_d    = alu_zr;
      end else begin
        cnt_d   = cnt_q - 1'b1;
        state_d = DBL;
      end
    end
  end

  assign req.busy    = busy_c;
  assign req.done    = done_c;
  assign req.product = product_q;
  assign req.zero    = zero_q;

`ifdef ALU_MUL_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: doubling with the top bit set, or an add that wraps.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE && req.start) begin
      ovf_d = 1'b0;
    end else if (state_q == DBL && acc_q[WIDTH-1]) begin
      ovf_d = 1'b1;
    end else if (state_q == ADD && alu_out < acc_q) begin
      ovf_d = 1'b1;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign req.ovf = ovf_q;
`else
  assign req.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed + random checks of alu_mul_seq against a plain
// arithmetic reference (a*b mod 2^16, latency 17+popcount(b)), with a
// behavioural Hack ALU attached to the sequencer's ALU pins.
module tb_alu_mul_seq;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] alu_x, alu_y, alu_out;
  logic         alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic         alu_zr, alu_ng;
  logic [5:0]   ctrl;

  int errors;
  int checks;

  alu_mul_seq_if #(.WIDTH(W)) req ();

  alu_mul_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .alu_x   (alu_x),
    .alu_y   (alu_y),
    .alu_zx  (alu_zx),
    .alu_nx  (alu_nx),
    .alu_zy  (alu_zy),
    .alu_ny  (alu_ny),
    .alu_f   (alu_f),
    .alu_no  (alu_no),
    .alu_out (alu_out),
    .alu_zr  (alu_zr),
    .alu_ng  (alu_ng)
  );

  assign ctrl = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural Hack ALU.
  always_comb begin
    logic [W-1:0] xx, yy, oo;
    xx = alu_zx ? '0 : alu_x;
    xx = alu_nx ? ~xx : xx;
    yy = alu_zy ? '0 : alu_y;
    yy = alu_ny ? ~yy : yy;
    oo = alu_f ? (xx + yy) : (xx & yy);
    oo = alu_no ? ~oo : oo;
    alu_out = oo;
    alu_zr  = (oo == '0);
    alu_ng  = oo[W-1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Run one multiply; optionally pulse start again (ga/gb) at cycle glitch.
  task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int glitch, input logic [W-1:0] ga, input logic [W-1:0] gb);
    logic [31:0] full;
    int exp_lat, lat, addc;
    logic exp_ovf;
    full    = 32'(a) * 32'(b);
    exp_lat = W + $countones(b) + 1;
`ifdef ALU_MUL_OVF_EN
    exp_ovf = (full > 32'h0000_FFFF);
`else
    exp_ovf = 1'b0;
`endif
    @(negedge clk);
    req.start = 1'b1;
    req.a     = a;
    req.b     = b;
    @(posedge clk);
    #1;
    req.start = 1'b0;
    lat  = 1;
    addc = 0;
    check({tag, "_busy_start"}, 32'(req.busy), 32'd1);
    while (!req.done && lat < 40) begin
      if (ctrl == 6'b000010) addc++;
      if (lat == glitch) begin
        req.start = 1'b1;
        req.a     = ga;
        req.b     = gb;
      end else begin
        req.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    req.start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_add_cycles"}, 32'(addc), 32'(exp_lat - 1));
    check({tag, "_product"}, 32'(req.product), full & 32'h0000_FFFF);
    check({tag, "_zero"}, 32'(req.zero), 32'((full & 32'h0000_FFFF) == 0));
    check({tag, "_ovf"}, 32'(req.ovf), 32'(exp_ovf));
    check({tag, "_busy_done"}, 32'(req.busy), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(req.done), 32'd0);
    check({tag, "_held"}, 32'(req.product), full & 32'h0000_FFFF);
    check({tag, "_idle_ctrl"}, 32'(ctrl), 32'b101010);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int lat;
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    req.start = 1'b0;
    req.a     = '0;
    req.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(req.busy), 32'd0);
    check("rst_done", 32'(req.done), 32'd0);
    check("rst_product", 32'(req.product), 32'd0);
    check("rst_zero", 32'(req.zero), 32'd1);
    check("rst_ovf", 32'(req.ovf), 32'd0);
    check("rst_ctrl", 32'(ctrl), 32'b101010);
    check("rst_xy", {alu_x, alu_y}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_mul("t17x3", 16'h0011, 16'h0003, 0, '0, '0);
    run_mul("t0xffff", 16'h0000, 16'hFFFF, 0, '0, '0);
    run_mul("tffff2", 16'hFFFF, 16'hFFFF, 0, '0, '0);
    run_mul("tb0", 16'h1234, 16'h0000, 0, '0, '0);
    run_mul("tignore", 16'h0005, 16'h0007, 4, 16'h0009, 16'h0009);

    // Reset in the middle of an operation.
    @(negedge clk);
    req.start = 1'b1;
    req.a     = 16'h00FF;
    req.b     = 16'h00FF;
    @(posedge clk);
    #1;
    req.start = 1'b0;
    lat = 1;
    while (lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("mid_busy_pre", 32'(req.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(req.busy), 32'd0);
    check("mid_rst_done", 32'(req.done), 32'd0);
    check("mid_rst_product", 32'(req.product), 32'd0);
    check("mid_rst_zero", 32'(req.zero), 32'd1);
    check("mid_rst_ctrl", 32'(ctrl), 32'b101010);
    check("mid_rst_xy", {alu_x, alu_y}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_mul("tafter_rst", 16'h00FF, 16'h00FF, 0, '0, '0);

    // Random operands.
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 5 == 1) ra = W'($urandom_range(0, 255));
      if (i % 5 == 2) rb = W'($urandom_range(0, 255));
      run_mul("trand", ra, rb, 0, '0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
